// File: rtl/serial_shift_out.sv
// serial_shift_out: parallel-in / serial-out transmitter, MSB first.
// A WIDTH-bit word is taken over a valid/ready handshake and shifted out one
// bit per clock. The ready window opens on the final bit of a frame, so words
// can follow each other with no idle cycle between them.
// Optional feature: define SERIAL_SHIFT_OUT_PARITY_EN to add an even-parity
// bit after the data bits. The frame is then WIDTH+1 cycles long.
module serial_shift_out #(
  parameter int WIDTH = 3
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load_valid_i,
  input  logic [WIDTH-1:0] load_data_i,
  output logic             load_ready_o,
  output logic             serial_o,
  output logic             serial_valid_o,
  output logic             done_o
);

  localparam int CNT_W = $clog2(WIDTH);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
`ifdef SERIAL_SHIFT_OUT_PARITY_EN
    PARITY = 2'd2,
`endif
    SHIFT  = 2'd1
  } state_t;

  state_t             state_reg, state_next;
  logic [WIDTH-1:0]   shreg_reg, shreg_next;
  logic [CNT_W-1:0]   count_reg, count_next;
`ifdef SERIAL_SHIFT_OUT_PARITY_EN
  logic               parity_reg, parity_next;
`endif
  logic               serial_next, valid_next, done_next, ready_next;
  logic               accept;

  // The handshake uses the registered ready, so the word is taken on the same edge the source sees.
  assign accept = load_valid_i & load_ready_o;

  // State register and registered outputs. Reset aborts any frame in flight at once.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg      <= IDLE;
      shreg_reg      <= '0;
      count_reg      <= '0;
`ifdef SERIAL_SHIFT_OUT_PARITY_EN
      parity_reg     <= 1'b0;
`endif
      serial_o       <= 1'b0;
      serial_valid_o <= 1'b0;
      done_o         <= 1'b0;
      load_ready_o   <= 1'b0;
    end else begin
      state_reg      <= state_next;
      shreg_reg      <= shreg_next;
      count_reg      <= count_next;
`ifdef SERIAL_SHIFT_OUT_PARITY_EN
      parity_reg     <= parity_next;
`endif
      serial_o       <= serial_next;
      serial_valid_o <= valid_next;
      done_o         <= done_next;
      load_ready_o   <= ready_next;
    end
  end

  // Next-state logic: shift and count through a frame, then either reload or go idle.
  always_comb begin
    state_next  = state_reg;
    shreg_next  = shreg_reg;
    count_next  = count_reg;
`ifdef SERIAL_SHIFT_OUT_PARITY_EN
    parity_next = parity_reg;
`endif
    case (state_reg)
      IDLE: begin
        count_next = '0;
      end
      SHIFT: begin
        shreg_next = shreg_reg << 1;
        if (count_reg == LAST) begin
`ifdef SERIAL_SHIFT_OUT_PARITY_EN
          state_next = PARITY;
`else
          state_next = IDLE;
          count_next = '0;
`endif
        end else begin
          count_next = count_reg + 1'b1;
        end
      end
`ifdef SERIAL_SHIFT_OUT_PARITY_EN
      PARITY: begin
        state_next = IDLE;
        count_next = '0;
      end
`endif
      default: begin
        state_next = IDLE;
        count_next = '0;
      end
    endcase
    // Ready is only high in IDLE or on a frame's final bit, so an accept always starts a fresh frame.
    if (accept) begin
      state_next  = SHIFT;
      shreg_next  = load_data_i;
      count_next  = '0;
`ifdef SERIAL_SHIFT_OUT_PARITY_EN
      parity_next = ^load_data_i;
`endif
    end
  end

  // Output logic: decode the upcoming state so that every output comes straight from a flop.
  always_comb begin
    serial_next = 1'b0;
    valid_next  = 1'b0;
    done_next   = 1'b0;
    ready_next  = 1'b0;
    case (state_next)
      IDLE: begin
        ready_next = 1'b1;
      end
      SHIFT: begin
        serial_next = shreg_next[WIDTH-1];
        valid_next  = 1'b1;
`ifndef SERIAL_SHIFT_OUT_PARITY_EN
        if (count_next == LAST) begin
          done_next  = 1'b1;
          ready_next = 1'b1;
        end
`endif
      end
`ifdef SERIAL_SHIFT_OUT_PARITY_EN
      PARITY: begin
        serial_next = parity_next;
        valid_next  = 1'b1;
        done_next   = 1'b1;
        ready_next  = 1'b1;
      end
`endif
      default: begin
        ready_next = 1'b0;
      end
    endcase
  end

endmodule

// File: tb/tb_serial_shift_out.sv
// Directed testbench for serial_shift_out with WIDTH=3.
// Outputs are sampled on the falling edge and compared as {serial, valid, done, ready}.
module tb_serial_shift_out;

  logic       clk;
  logic       rst_n;
  logic       load_valid_i;
  logic [2:0] load_data_i;
  logic       load_ready_o;
  logic       serial_o;
  logic       serial_valid_o;
  logic       done_o;

  int checks;
  int failures;

  // A serial-in capture register that samples on serial_valid_o.
  logic [2:0] cap;

  serial_shift_out #(.WIDTH(3)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .load_valid_i   (load_valid_i),
    .load_data_i    (load_data_i),
    .load_ready_o   (load_ready_o),
    .serial_o       (serial_o),
    .serial_valid_o (serial_valid_o),
    .done_o         (done_o)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) cap <= 3'b000;
    else if (serial_valid_o) cap <= {cap[1:0], serial_o};
  end

  task automatic test_reset();
    logic [3:0] obs;
    rst_n = 1'b0;
    load_valid_i = 1'b0;
    load_data_i = 3'b000;
    @(negedge clk);
    @(negedge clk);
    obs = {serial_o, serial_valid_o, done_o, load_ready_o};
    checks++;
    if (obs !== 4'b0000) begin
      failures++;
      $display("FAIL reset_state: got %b expected 0000", obs);
    end
    rst_n = 1'b1;
    @(negedge clk);
    obs = {serial_o, serial_valid_o, done_o, load_ready_o};
    checks++;
    if (obs !== 4'b0001) begin
      failures++;
      $display("FAIL reset_release_ready: got %b expected 0001", obs);
    end
    $display("test_reset: checked");
  endtask

`ifndef SERIAL_SHIFT_OUT_PARITY_EN
  task automatic test_single();
    logic [2:0] w;
    logic [3:0] obs, exp;
    w = 3'b101;
    load_data_i = w;
    load_valid_i = 1'b1;
    @(negedge clk);
    load_valid_i = 1'b0;
    load_data_i = 3'b000;
    for (int k = 0; k < 5; k++) begin
      if (k > 0) @(negedge clk);
      exp = (k < 3) ? {w[2-k], 1'b1, (k == 2), (k == 2)} : 4'b0001;
      obs = {serial_o, serial_valid_o, done_o, load_ready_o};
      checks++;
      if (obs !== exp) begin
        failures++;
        $display("FAIL single_101 cycle %0d: got %b expected %b", k + 1, obs, exp);
      end
    end
    $display("test_single: word 101 sent");
  endtask

  task automatic test_back_to_back();
    logic [5:0] s, d;
    logic [3:0] obs, exp;
    s = 6'b110011;
    d = 6'b001001;
    load_data_i = 3'b110;
    load_valid_i = 1'b1;
    @(negedge clk);
    for (int k = 0; k < 7; k++) begin
      if (k > 0) @(negedge clk);
      exp = (k < 6) ? {s[5-k], 1'b1, d[5-k], d[5-k]} : 4'b0001;
      obs = {serial_o, serial_valid_o, done_o, load_ready_o};
      checks++;
      if (obs !== exp) begin
        failures++;
        $display("FAIL back_to_back cycle %0d: got %b expected %b", k + 1, obs, exp);
      end
      if (k == 0) load_data_i = 3'b011;
      if (k == 2) begin
        @(posedge clk);
        #1 load_valid_i = 1'b0;
        load_data_i = 3'b000;
      end
    end
    $display("test_back_to_back: words 110,011 sent");
  endtask

  task automatic test_ignore_busy();
    logic [5:0] s, d;
    logic [3:0] obs, exp;
    s = 6'b100111;
    d = 6'b001001;
    load_data_i = 3'b100;
    load_valid_i = 1'b1;
    @(negedge clk);
    load_valid_i = 1'b0;
    for (int k = 0; k < 8; k++) begin
      if (k > 0) @(negedge clk);
      exp = (k < 6) ? {s[5-k], 1'b1, d[5-k], d[5-k]} : 4'b0001;
      obs = {serial_o, serial_valid_o, done_o, load_ready_o};
      checks++;
      if (obs !== exp) begin
        failures++;
        $display("FAIL ignore_busy cycle %0d: got %b expected %b", k + 1, obs, exp);
      end
      if (k == 1) begin
        load_data_i = 3'b111;
        load_valid_i = 1'b1;
      end
      if (k == 3) begin
        load_valid_i = 1'b0;
        load_data_i = 3'b000;
      end
    end
    $display("test_ignore_busy: words 100,111 sent");
  endtask

  task automatic test_reset_mid_frame();
    logic [2:0] w;
    logic [3:0] obs, exp;
    load_data_i = 3'b101;
    load_valid_i = 1'b1;
    @(negedge clk);
    load_valid_i = 1'b0;
    @(negedge clk);
    obs = {serial_o, serial_valid_o, done_o, load_ready_o};
    checks++;
    if (obs !== 4'b0100) begin
      failures++;
      $display("FAIL mid_reset_second_bit: got %b expected 0100", obs);
    end
    #2 rst_n = 1'b0;
    #1;
    obs = {serial_o, serial_valid_o, done_o, load_ready_o};
    checks++;
    if (obs !== 4'b0000) begin
      failures++;
      $display("FAIL mid_reset_async: got %b expected 0000", obs);
    end
    @(negedge clk);
    obs = {serial_o, serial_valid_o, done_o, load_ready_o};
    checks++;
    if (obs !== 4'b0000) begin
      failures++;
      $display("FAIL mid_reset_held: got %b expected 0000", obs);
    end
    rst_n = 1'b1;
    @(negedge clk);
    obs = {serial_o, serial_valid_o, done_o, load_ready_o};
    checks++;
    if (obs !== 4'b0001) begin
      failures++;
      $display("FAIL mid_reset_idle: got %b expected 0001", obs);
    end
    w = 3'b010;
    load_data_i = w;
    load_valid_i = 1'b1;
    @(negedge clk);
    load_valid_i = 1'b0;
    for (int k = 0; k < 4; k++) begin
      if (k > 0) @(negedge clk);
      exp = (k < 3) ? {w[2-k], 1'b1, (k == 2), (k == 2)} : 4'b0001;
      obs = {serial_o, serial_valid_o, done_o, load_ready_o};
      checks++;
      if (obs !== exp) begin
        failures++;
        $display("FAIL after_reset_010 cycle %0d: got %b expected %b", k + 1, obs, exp);
      end
    end
    $display("test_reset_mid_frame: aborted 101, then sent 010");
  endtask

  task automatic test_loopback();
    logic [2:0] w;
    for (int v = 0; v < 8; v++) begin
      w = 3'(v);
      load_data_i = w;
      load_valid_i = 1'b1;
      @(negedge clk);
      load_valid_i = 1'b0;
      repeat (3) @(negedge clk);
      checks++;
      if (cap !== w) begin
        failures++;
        $display("FAIL loopback word %0d: captured %b expected %b", v, cap, w);
      end
      $display("test_loopback: word %b captured %b", w, cap);
    end
  endtask
`else
  task automatic test_parity();
    logic [7:0] s, d;
    logic [3:0] obs, exp;
    s = 8'b1010_1001;
    d = 8'b0001_0001;
    load_data_i = 3'b101;
    load_valid_i = 1'b1;
    @(negedge clk);
    for (int k = 0; k < 9; k++) begin
      if (k > 0) @(negedge clk);
      exp = (k < 8) ? {s[7-k], 1'b1, d[7-k], d[7-k]} : 4'b0001;
      obs = {serial_o, serial_valid_o, done_o, load_ready_o};
      checks++;
      if (obs !== exp) begin
        failures++;
        $display("FAIL parity cycle %0d: got %b expected %b", k + 1, obs, exp);
      end
      if (k == 0) load_data_i = 3'b100;
      if (k == 4) begin
        load_valid_i = 1'b0;
        load_data_i = 3'b000;
      end
    end
    $display("test_parity: words 101,100 sent with parity");
  endtask
`endif

  initial begin
    checks = 0;
    failures = 0;
    test_reset();
`ifndef SERIAL_SHIFT_OUT_PARITY_EN
    test_single();
    test_back_to_back();
    test_ignore_busy();
    test_reset_mid_frame();
    test_loopback();
`else
    test_parity();
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
